// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over req/gnt/rvalid, holds the instruction until commit.
// Optional build macro MISALIGN_CHECK_EN adds misalign_trap and a terminal S_TRAP state for taken branches with target[1]=1.
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            ex_done,
    input  logic            stall,
    input  logic            nextPcsrc,
    input  logic [XLEN-1:0] branch_target,
    output logic [31:0]     instret
`ifdef MISALIGN_CHECK_EN
    ,
    output logic            misalign_trap
`endif
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_EXEC
`ifdef MISALIGN_CHECK_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_instr_valid;
    logic [31:0]     r_instret;
    logic            w_fetch_done;
    logic            w_commit;
    logic            w_trap;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_pc_plus4   = r_pc + XLEN'(4);
    assign w_target     = branch_target & ~XLEN'(1);
    assign w_fetch_done = ((r_state == S_REQ) && imem_gnt && imem_rvalid) ||
                          ((r_state == S_WAIT) && imem_rvalid);
    assign w_commit     = (r_state == S_EXEC) && ex_done && !stall;
`ifdef MISALIGN_CHECK_EN
    assign w_trap       = w_commit && nextPcsrc && branch_target[1];
`else
    assign w_trap       = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT: w_state_next = S_REQ;
            S_REQ: begin
                if (imem_gnt) w_state_next = imem_rvalid ? S_EXEC : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) w_state_next = S_EXEC;
            end
            S_EXEC: begin
`ifdef MISALIGN_CHECK_EN
                if (w_trap)        w_state_next = S_TRAP;
                else if (w_commit) w_state_next = S_REQ;
`else
                if (w_commit) w_state_next = S_REQ;
`endif
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fetch_done) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            // A trapping commit still retires nothing and leaves pc on the faulting branch.
            if (w_commit) begin
                r_instr_valid <= 1'b0;
                if (!w_trap) begin
                    r_pc      <= nextPcsrc ? w_target : w_pc_plus4;
                    r_instret <= r_instret + 32'd1;
                end
            end
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic r_misalign_trap;
    always_ff @(posedge clk) begin
        if (rst)         r_misalign_trap <= 1'b0;
        else if (w_trap) r_misalign_trap <= 1'b1;
    end
    assign misalign_trap = r_misalign_trap;
`endif

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign instret     = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential flow, branches, backpressure, mid-fetch reset, wrap, misaligned target.
module tb_pc_sequencer;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            ex_done;
    logic            stall;
    logic            nextPcsrc;
    logic [XLEN-1:0] branch_target;
    logic [31:0]     instret;
`ifdef MISALIGN_CHECK_EN
    logic            misalign_trap;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .ex_done(ex_done), .stall(stall), .nextPcsrc(nextPcsrc),
        .branch_target(branch_target), .instret(instret)
`ifdef MISALIGN_CHECK_EN
        , .misalign_trap(misalign_trap)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit the executing instruction with a sequential next PC, then fetch the next word with zero wait.
    task automatic commit_seq_and_fetch(input logic [31:0] word);
        ex_done = 1'b1; nextPcsrc = 1'b0;
        tick();
        ex_done = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = word;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        ex_done = 1'b0; stall = 1'b0; nextPcsrc = 1'b0; branch_target = '0;
        tick(); tick();
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (pc !== RESET_PC) $display("FAIL rst_pc got=%h exp=%h", pc, RESET_PC); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr); else n_pass++;
        n_total++; if (instret !== 32'h0) $display("FAIL rst_instret got=%h exp=0", instret); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL boot_req got=%b/%h exp=1/00000100", imem_req, imem_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL boot_valid got=%b exp=0", instr_valid); else n_pass++;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hA0A0_0013;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b1 || instr !== 32'hA0A0_0013) $display("FAIL first_fetch got=%b/%h exp=1/a0a00013", instr_valid, instr); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL exec_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h104) $display("FAIL pc_plus4 got=%h exp=00000104", pc_plus4); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h104; exp_addr[1] = 32'h108; exp_addr[2] = 32'h10C;
        // Holding EXEC without ex_done must not move the pc even with a branch request present.
        nextPcsrc = 1'b1; branch_target = 32'h0000_0800;
        tick(); tick();
        n_total++; if (pc !== 32'h100 || instr_valid !== 1'b1) $display("FAIL exec_hold got=%h/%b exp=00000100/1", pc, instr_valid); else n_pass++;
        branch_target = 32'hDEAD_BEE0;
        for (int i = 0; i < 3; i++) begin
            ex_done = 1'b1; nextPcsrc = 1'b0;
            tick();
            ex_done = 1'b0;
            n_total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr[i]) $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, exp_addr[i]); else n_pass++;
            n_total++; if (instr_valid !== 1'b0) $display("FAIL seq_valid_clr%0d got=%b exp=0", i, instr_valid); else n_pass++;
            imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0000 + i;
            tick();
            imem_gnt = 1'b0; imem_rvalid = 1'b0;
            n_total++; if (instr !== 32'h1000_0000 + i) $display("FAIL seq_instr%0d got=%h exp=%h", i, instr, 32'h1000_0000 + i); else n_pass++;
        end
        n_total++; if (instret !== 32'd3) $display("FAIL seq_instret got=%0d exp=3", instret); else n_pass++;
    endtask

    task automatic test_branch();
        ex_done = 1'b1; nextPcsrc = 1'b1; branch_target = 32'h0000_0041;
        tick();
        ex_done = 1'b0; nextPcsrc = 1'b0;
        n_total++; if (imem_addr !== 32'h40) $display("FAIL br_addr got=%h exp=00000040", imem_addr); else n_pass++;
        n_total++; if (instret !== 32'd4) $display("FAIL br_instret got=%0d exp=4", instret); else n_pass++;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0040_0093;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b1 || pc !== 32'h40) $display("FAIL br_exec got=%b/%h exp=1/00000040", instr_valid, pc); else n_pass++;
    endtask

    task automatic test_backpressure();
        ex_done = 1'b1;
        tick();
        n_total++; if (imem_addr !== 32'h44 || instret !== 32'd5) $display("FAIL bp_start got=%h/%0d exp=00000044/5", imem_addr, instret); else n_pass++;
        // ex_done outside EXEC is ignored.
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) $display("FAIL bp_hold%0d got=%b/%h exp=1/00000044", i, imem_req, imem_addr); else n_pass++;
        end
        n_total++; if (instret !== 32'd5) $display("FAIL bp_stray_exdone got=%0d exp=5", instret); else n_pass++;
        ex_done = 1'b0; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        n_total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL bp_wait got=%b/%b exp=0/0", imem_req, instr_valid); else n_pass++;
        tick(); tick();
        n_total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL bp_wait_hold got=%b/%b exp=0/0", imem_req, instr_valid); else n_pass++;
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0033;
        tick();
        imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0033) $display("FAIL bp_fetch got=%b/%h exp=1/cafe0033", instr_valid, instr); else n_pass++;
        stall = 1'b1; ex_done = 1'b1;
        tick(); tick();
        n_total++; if (instret !== 32'd5 || pc !== 32'h44 || instr_valid !== 1'b1) $display("FAIL bp_stall got=%0d/%h/%b exp=5/00000044/1", instret, pc, instr_valid); else n_pass++;
        stall = 1'b0;
        tick();
        ex_done = 1'b0;
        n_total++; if (instret !== 32'd6 || imem_addr !== 32'h48 || imem_req !== 1'b1) $display("FAIL bp_release got=%0d/%h/%b exp=6/00000048/1", instret, imem_addr, imem_req); else n_pass++;
    endtask

    task automatic test_reset_midfetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        n_total++; if (pc !== RESET_PC || instr_valid !== 1'b0 || instret !== 32'd0 || imem_req !== 1'b0) $display("FAIL mid_rst got=%h/%b/%0d/%b exp=00000100/0/0/0", pc, instr_valid, instret, imem_req); else n_pass++;
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b0 || instr !== 32'h0) $display("FAIL mid_stale got=%b/%h exp=0/00000000", instr_valid, instr); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL mid_restart got=%b/%h exp=1/00000100", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) $display("FAIL mid_req_hold got=%b/%b exp=1/0", imem_req, instr_valid); else n_pass++;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0513) $display("FAIL mid_refetch got=%b/%h exp=1/00000513", instr_valid, instr); else n_pass++;
    endtask

    task automatic test_wrap();
        ex_done = 1'b1; nextPcsrc = 1'b1; branch_target = 32'hFFFF_FFFD;
        tick();
        ex_done = 1'b0; nextPcsrc = 1'b0;
        n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); else n_pass++;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        commit_seq_and_fetch(32'h0000_0093);
        n_total++; if (pc !== 32'h0 || instret !== 32'd2) $display("FAIL wrap_pc got=%h/%0d exp=00000000/2", pc, instret); else n_pass++;
    endtask

    task automatic test_misalign();
        ex_done = 1'b1; nextPcsrc = 1'b1; branch_target = 32'h0000_0042;
        tick();
        ex_done = 1'b0; nextPcsrc = 1'b0;
`ifdef MISALIGN_CHECK_EN
        n_total++; if (misalign_trap !== 1'b1) $display("FAIL mis_trap got=%b exp=1", misalign_trap); else n_pass++;
        n_total++; if (pc !== 32'h0 || instret !== 32'd2) $display("FAIL mis_pc got=%h/%0d exp=00000000/2", pc, instret); else n_pass++;
        imem_gnt = 1'b1; imem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL mis_hold%0d got=%b/%b exp=0/0", i, imem_req, instr_valid); else n_pass++;
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (misalign_trap !== 1'b0 || pc !== RESET_PC) $display("FAIL mis_rst got=%b/%h exp=0/00000100", misalign_trap, pc); else n_pass++;
        tick();
        n_total++; if (imem_req !== 1'b1) $display("FAIL mis_restart got=%b exp=1", imem_req); else n_pass++;
`else
        n_total++; if (imem_addr !== 32'h42 || imem_req !== 1'b1) $display("FAIL mis_pass got=%h/%b exp=00000042/1", imem_addr, imem_req); else n_pass++;
        n_total++; if (instret !== 32'd3) $display("FAIL mis_instret got=%0d exp=3", instret); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_backpressure();
        test_reset_midfetch();
        test_wrap();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
